// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared FSM state and owner encodings for the memory port arbiter
package mem_port_arbiter_pkg;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'b00;
  localparam state_t ST_ACCESS = 2'b01;
  localparam state_t ST_RESP = 2'b10;
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;
endpackage

// File: rtl/mem_port_arbiter_wait_counter.sv
// mem_port_arbiter_wait_counter: saturating count of cycles IF has waited, flags when it must win
module mem_port_arbiter_wait_counter #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  localparam int W = $clog2(MAX_WAIT + 1);
  logic [W-1:0] cnt;
  assign sat = cnt >= W'(MAX_WAIT);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !sat) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory between instruction fetch and data access with IF anti-starvation
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wd,
  input  logic [DATA_W-1:0] rd
);
  state_t state;
  logic owner, sat, dm_req, grant_if, if_busy;
  assign dm_req = dm_read | dm_write;
  assign grant_if = if_req && (!dm_req || sat);
  assign if_busy = state != ST_IDLE && owner == OWN_IF;
  mem_port_arbiter_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .clk(clk),
    .rst_n(rst_n),
    .inc(if_req && !if_busy),
    .clr(state == ST_IDLE && grant_if),
    .sat(sat)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      owner <= OWN_IF;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      addr <= '0;
      wd <= '0;
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      if_valid <= state == ST_ACCESS && owner == OWN_IF;
      dm_valid <= state == ST_ACCESS && owner == OWN_DM;
      if (state == ST_IDLE && (if_req || dm_req)) begin
        state <= ST_ACCESS;
        owner <= grant_if ? OWN_IF : OWN_DM;
        addr <= grant_if ? if_addr : dm_addr;
        if (!grant_if) wd <= dm_wdata;
        mem_read <= grant_if || !dm_write;
        mem_write <= !grant_if && dm_write;
      end else if (state == ST_ACCESS) begin
        state <= ST_RESP;
        mem_read <= 1'b0;
        mem_write <= 1'b0;
        if (mem_read && owner == OWN_IF) if_rdata <= rd;
        if (mem_read && owner == OWN_DM) dm_rdata <= rd;
      end else if (state != ST_IDLE) begin
        state <= ST_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard-driven checks of arbitration, latency, reset and write priority
module tb_mem_port_arbiter;
  typedef struct packed {logic dm; logic [31:0] addr; logic [31:0] data;} txn_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic if_req = 1'b0, dm_read = 1'b0, dm_write = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic [31:0] if_rdata, dm_rdata, addr, wd, rd;
  logic if_valid, dm_valid, mem_read, mem_write;
  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  txn_t exp_q[$];
  txn_t e;
  int errors = 0, checks = 0;
  int lat, acc, total;
  logic aw, ar, seen;
  logic [31:0] aa, awd;
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_read(mem_read), .mem_write(mem_write), .addr(addr), .wd(wd), .rd(rd)
  );
  always #5 clk = ~clk;
  assign rd = mem[addr[9:2]];
  always @(posedge clk) if (mem_write) mem[addr[9:2]] = wd;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  task automatic run_until(input logic want_dm, output int n, output int na, output logic w, output logic r,
                           output logic [31:0] a, output logic [31:0] d, output logic ok);
    n = 0; na = 0; w = 0; r = 0; a = '0; d = '0; ok = 0;
    while (!ok && n < 12) begin
      @(negedge clk);
      n++;
      if (mem_read || mem_write) begin na++; w = mem_write; r = mem_read; a = addr; d = wd; end
      ok = want_dm ? dm_valid : if_valid;
    end
  endtask
  task automatic test_reset();
    logic busy = 1'b0;
    #2;
    checks++; if ({mem_read, mem_write, if_valid, dm_valid} !== 4'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 0000", {mem_read, mem_write, if_valid, dm_valid}); end
    checks++; if ({addr, wd, if_rdata, dm_rdata} !== 128'b0) begin errors++; $display("FAIL reset_data: got %h want 0", {addr, wd, if_rdata, dm_rdata}); end
    @(negedge clk); rst_n = 1'b1;
    repeat (5) begin @(negedge clk); busy = busy | mem_read | mem_write; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_quiet: got %b want 0", busy); end
  endtask
  task automatic test_dm_write_read();
    @(negedge clk);
    dm_write = 1; dm_addr = 88; dm_wdata = 32'h12345678;
    ref_mem[22] = 32'h12345678;
    exp_q.push_back('{1'b1, 32'd88, 32'h12345678});
    run_until(1, lat, acc, aw, ar, aa, awd, seen);
    dm_write = 0;
    e = exp_q.pop_front();
    checks++; if (seen !== 1'b1 || lat !== 2) begin errors++; $display("FAIL wr_latency: got %0d seen=%b want 2", lat, seen); end
    checks++; if (acc !== 1 || aw !== 1'b1 || aa !== e.addr || awd !== e.data) begin errors++; $display("FAIL wr_access: got n=%0d wr=%b a=%0d d=%h want n=1 wr=1 a=%0d d=%h", acc, aw, aa, awd, e.addr, e.data); end
    @(negedge clk);
    dm_read = 1; dm_addr = 88;
    exp_q.push_back('{1'b1, 32'd88, ref_mem[22]});
    run_until(1, lat, acc, aw, ar, aa, awd, seen);
    dm_read = 0;
    e = exp_q.pop_front();
    checks++; if (seen !== 1'b1 || lat !== 2) begin errors++; $display("FAIL rd_latency: got %0d seen=%b want 2", lat, seen); end
    checks++; if (ar !== 1'b1 || aw !== 1'b0 || aa !== e.addr) begin errors++; $display("FAIL rd_access: got rd=%b wr=%b a=%0d want rd=1 wr=0 a=%0d", ar, aw, aa, e.addr); end
    checks++; if (dm_rdata !== e.data) begin errors++; $display("FAIL rd_data: got %h want %h", dm_rdata, e.data); end
  endtask
  task automatic test_contention();
    @(negedge clk);
    if_req = 1; if_addr = 0; dm_read = 1; dm_addr = 4;
    exp_q.push_back('{1'b1, 32'd4, ref_mem[1]});
    exp_q.push_back('{1'b0, 32'd0, ref_mem[0]});
    run_until(1, lat, acc, aw, ar, aa, awd, seen);
    dm_read = 0;
    total = lat;
    e = exp_q.pop_front();
    checks++; if (seen !== 1'b1 || lat !== 2 || aa !== e.addr || if_valid !== 1'b0) begin errors++; $display("FAIL cont_dm_first: got lat=%0d a=%0d ifv=%b want lat=2 a=%0d ifv=0", lat, aa, if_valid, e.addr); end
    checks++; if (dm_rdata !== e.data) begin errors++; $display("FAIL cont_dm_data: got %h want %h", dm_rdata, e.data); end
    run_until(0, lat, acc, aw, ar, aa, awd, seen);
    if_req = 0;
    total += lat;
    e = exp_q.pop_front();
    checks++; if (seen !== 1'b1 || total !== 5) begin errors++; $display("FAIL cont_if_latency: got %0d seen=%b want 5", total, seen); end
    checks++; if (acc !== 1 || aa !== e.addr || if_rdata !== e.data) begin errors++; $display("FAIL cont_if_data: got n=%0d a=%0d d=%h want n=1 a=%0d d=%h", acc, aa, if_rdata, e.addr, e.data); end
  endtask
  task automatic test_starvation();
    int done = 0, n = 0;
    exp_q.push_back('{1'b1, 32'd12, ref_mem[3]});
    exp_q.push_back('{1'b1, 32'd16, ref_mem[4]});
    exp_q.push_back('{1'b0, 32'd8, ref_mem[2]});
    exp_q.push_back('{1'b1, 32'd20, ref_mem[5]});
    exp_q.push_back('{1'b1, 32'd24, ref_mem[6]});
    exp_q.push_back('{1'b0, 32'd28, ref_mem[7]});
    @(negedge clk);
    if_req = 1; if_addr = 8; dm_read = 1; dm_addr = 12;
    while (done < 6 && n < 60) begin
      @(negedge clk);
      n++;
      if (dm_valid || if_valid) begin
        e = exp_q.pop_front();
        done++;
        checks++; if (dm_valid !== e.dm || (dm_valid && if_valid)) begin errors++; $display("FAIL starve_order%0d: got dm=%b if=%b want dm=%b", done, dm_valid, if_valid, e.dm); end
        checks++; if ((dm_valid ? dm_rdata : if_rdata) !== e.data) begin errors++; $display("FAIL starve_data%0d: got %h want %h", done, dm_valid ? dm_rdata : if_rdata, e.data); end
        if (dm_valid) dm_addr = dm_addr + 4;
        else if_addr = 28;
      end
    end
    if_req = 0; dm_read = 0;
    checks++; if (done !== 6 || exp_q.size() !== 0) begin errors++; $display("FAIL starve_count: got %0d left=%0d want 6 left=0", done, exp_q.size()); end
  endtask
  task automatic test_reset_mid();
    logic v = 1'b0;
    @(negedge clk);
    dm_write = 1; dm_addr = 92; dm_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (mem_write !== 1'b1 || addr !== 32'd92) begin errors++; $display("FAIL mid_access: got wr=%b a=%0d want wr=1 a=92", mem_write, addr); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (mem_write !== 1'b0 || addr !== 32'd0) begin errors++; $display("FAIL mid_abort: got wr=%b a=%0d want wr=0 a=0", mem_write, addr); end
    dm_write = 0;
    repeat (2) begin @(negedge clk); v = v | dm_valid; end
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL mid_novalid: got %b want 0", v); end
    rst_n = 1'b1;
    @(negedge clk);
    dm_read = 1; dm_addr = 92;
    exp_q.push_back('{1'b1, 32'd92, ref_mem[23]});
    run_until(1, lat, acc, aw, ar, aa, awd, seen);
    dm_read = 0;
    e = exp_q.pop_front();
    checks++; if (seen !== 1'b1 || lat !== 2 || dm_rdata !== e.data) begin errors++; $display("FAIL mid_fresh: got lat=%0d d=%h want lat=2 d=%h", lat, dm_rdata, e.data); end
  endtask
  task automatic test_both_cmd();
    @(negedge clk);
    dm_read = 1; dm_write = 1; dm_addr = 96; dm_wdata = 32'hCAFEF00D;
    exp_q.push_back('{1'b1, 32'd96, 32'hCAFEF00D});
    run_until(1, lat, acc, aw, ar, aa, awd, seen);
    dm_read = 0; dm_write = 0;
    ref_mem[24] = 32'hCAFEF00D;
    e = exp_q.pop_front();
    checks++; if (seen !== 1'b1 || aw !== 1'b1 || ar !== 1'b0 || aa !== e.addr || awd !== e.data) begin errors++; $display("FAIL both_is_write: got wr=%b rd=%b a=%0d d=%h want wr=1 rd=0 a=%0d d=%h", aw, ar, aa, awd, e.addr, e.data); end
    checks++; if (dm_rdata !== ref_mem[23]) begin errors++; $display("FAIL both_rdata_hold: got %h want %h", dm_rdata, ref_mem[23]); end
    @(negedge clk);
    dm_read = 1; dm_addr = 96;
    exp_q.push_back('{1'b1, 32'd96, 32'hCAFEF00D});
    run_until(1, lat, acc, aw, ar, aa, awd, seen);
    dm_read = 0;
    e = exp_q.pop_front();
    checks++; if (seen !== 1'b1 || dm_rdata !== e.data) begin errors++; $display("FAIL both_readback: got %h want %h", dm_rdata, e.data); end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'h1000_0000 + i * 32'h0001_0003;
      ref_mem[i] = 32'h1000_0000 + i * 32'h0001_0003;
    end
    test_reset();
    test_dm_write_read();
    test_contention();
    test_starvation();
    test_reset_mid();
    test_both_cmd();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
